// File: rtl/mul4_nibble_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mul4_nibble_sequencer_pkg
//   Shared definitions for the nibble-serial multiply/accumulate sequencer:
//   the nibble width and the controller state encoding.
// ---------------------------------------------------------------------------
package mul4_nibble_sequencer_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MUL   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mul4_nibble_sequencer_mul4x4_array.sv
// ---------------------------------------------------------------------------
// mul4x4_array
//   Purely combinational 4x4 unsigned array multiplier. Partial-product rows
//   are summed by ripple chains of full-adder cells.
// Ports:
//   a [3:0]  in   multiplicand nibble
//   b [3:0]  in   multiplier nibble
//   p [7:0]  out  unsigned product a*b
// ---------------------------------------------------------------------------
module mul4x4_array
    import mul4_nibble_sequencer_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    // pp[r] is row r of the AND matrix, weight 2^r
    logic [NIB_W-1:0] pp [NIB_W];

    genvar gi;
    generate
        for (gi = 0; gi < NIB_W; gi++) begin : g_pp_row
            assign pp[gi] = a & {NIB_W{b[gi]}};
        end
    endgenerate

    // Full-adder cell: returns {carry_out, sum}
    function automatic logic [1:0] fa(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

    logic [NIB_W-1:0] hi;       // running upper bits carried into the next row
    logic [NIB_W-1:0] row_sum;
    logic             carry;
    logic [1:0]       fa_out;

    // Each row r adds pp[r] to the upper bits left by row r-1; the LS bit of
    // the row sum is final product bit r, the rest (plus carry) moves on.
    always_comb begin
        p       = '0;
        row_sum = '0;
        carry   = 1'b0;
        fa_out  = '0;
        hi      = {1'b0, pp[0][NIB_W-1:1]};
        p[0]    = pp[0][0];
        for (int r = 1; r < NIB_W; r++) begin
            carry = 1'b0;
            for (int c = 0; c < NIB_W; c++) begin
                fa_out     = fa(pp[r][c], hi[c], carry);
                row_sum[c] = fa_out[0];
                carry      = fa_out[1];
            end
            p[r] = row_sum[0];
            hi   = {carry, row_sum[NIB_W-1:1]};
        end
        p[2*NIB_W-1:NIB_W] = hi;
    end

endmodule

// File: rtl/mul4_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// mul4_nibble_sequencer
//   Computes a 2W-bit unsigned product (W = 4*OP_NIBBLES), optionally added
//   to the running accumulator, using one shared 4x4 multiplier stepped over
//   all nibble pairs. Operands enter and the result leaves nibble-serially.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand nibble handshake; in_nib carries A then B, LS first
//   acc_mode             sampled with the first nibble: 1 = add to acc, 0 = replace
//   clr_acc              clears acc while idle
//   out_valid/out_ready  result nibble handshake; out_nib LS first
//   busy                 controller not idle
//   done                 one-cycle pulse after the final result nibble transfer
// ---------------------------------------------------------------------------
module mul4_nibble_sequencer
    import mul4_nibble_sequencer_pkg::*;
#(
    parameter int OP_NIBBLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB_W-1:0] in_nib,
    input  logic             acc_mode,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIB_W-1:0] out_nib,
    output logic             busy,
    output logic             done
);

    localparam int W       = NIB_W * OP_NIBBLES;
    localparam int RW      = 2 * W;
    localparam int NIBS    = 2 * OP_NIBBLES;  // operand nibbles in == result nibbles out
    localparam int CNT_W   = $clog2(NIBS);
    localparam int IDX_W   = (OP_NIBBLES > 1) ? $clog2(OP_NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OP_NIBBLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [RW-1:0]    opnd_q, opnd_d;   // {B, A}: nibble n of the input stream lands at bits 4n+3:4n
    logic [RW-1:0]    sum_q, sum_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic [NIB_W-1:0]   mul_a, mul_b;
    logic [2*NIB_W-1:0] mul_p;
    logic [RW-1:0]      pp_shifted;
    logic [RW-1:0]      sum_next;

    // Multiplier operands are selected only by the current i/j indices
    assign mul_a = opnd_q[int'(i_q) * NIB_W +: NIB_W];
    assign mul_b = opnd_q[W + int'(j_q) * NIB_W +: NIB_W];

    mul4x4_array u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Partial product aligned to weight 16^(i+j); overflow past 2W bits wraps
    assign pp_shifted = RW'(mul_p) << ((int'(i_q) + int'(j_q)) * NIB_W);
    assign sum_next   = sum_q + pp_shifted;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_nib   = out_valid ? acc_q[int'(k_q) * NIB_W +: NIB_W] : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        opnd_d  = opnd_q;
        sum_d   = sum_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr_acc) begin
                    acc_d = '0;
                end
                if (in_valid) begin
                    opnd_d[NIB_W-1:0] = in_nib;
                    mode_d            = acc_mode;
                    cnt_d             = CNT_W'(1);
                    state_d           = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    opnd_d[int'(cnt_q) * NIB_W +: NIB_W] = in_nib;
                    if (cnt_q == LAST_NIB) begin
                        state_d = ST_MUL;
                        i_d     = '0;
                        j_d     = '0;
                        // acc_q here already reflects any clear taken in IDLE
                        sum_d   = mode_q ? acc_q : '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_MUL: begin
                sum_d = sum_next;
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    if (i_q == LAST_IDX) begin
                        acc_d   = sum_next;
                        k_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        i_d = i_q + IDX_W'(1);
                    end
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (k_q == LAST_NIB) begin
                        k_d     = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            opnd_q  <= '0;
            sum_q   <= '0;
            acc_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            opnd_q  <= opnd_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mul4_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul4_nibble_sequencer
//   Self-checking bench: one instance with OP_NIBBLES=2 and one with
//   OP_NIBBLES=1. Expected results come from plain arithmetic on a
//   reference accumulator.
// ---------------------------------------------------------------------------
module tb_mul4_nibble_sequencer;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, acc_mode, clr_acc, out_ready;
    logic [3:0] in_nib;
    logic       in_ready, out_valid, busy, done;
    logic [3:0] out_nib;

    logic       in_valid1, acc_mode1, clr_acc1, out_ready1;
    logic [3:0] in_nib1;
    logic       in_ready1, out_valid1, busy1, done1;
    logic [3:0] out_nib1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] acc_ref;
    logic [7:0]  acc_ref1;
    logic [15:0] last_res;
    logic [7:0]  last_res1;

    mul4_nibble_sequencer #(.OP_NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_nib(in_nib), .acc_mode(acc_mode), .clr_acc(clr_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_nib(out_nib),
        .busy(busy), .done(done)
    );

    mul4_nibble_sequencer #(.OP_NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_nib(in_nib1), .acc_mode(acc_mode1), .clr_acc(clr_acc1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_nib(out_nib1),
        .busy(busy1), .done(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the OP_NIBBLES=2 instance; returns the drained result
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic mode,
                          input bit bubbles, input int stall_k, input int stall_len,
                          input bit clr_in_load, input bit junk, output logic [15:0] res);
        logic [3:0] nibs [4];
        logic [3:0] held;
        int         lat;
        nibs[0] = a[3:0]; nibs[1] = a[7:4]; nibs[2] = b[3:0]; nibs[3] = b[7:4];
        res = '0;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        for (int n = 0; n < 4; n++) begin
            if (bubbles) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0; in_nib = 4'($urandom); acc_mode = ~mode;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_nib   = nibs[n];
            acc_mode = (n == 0) ? mode : ~mode;
            tick();
            if (n == 0 && clr_in_load) clr_acc = 1'b1;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat == 0) begin
                check_eq("in_ready_mul", 32'(in_ready), 32'd0);
                check_eq("busy_mul", 32'(busy), 32'd1);
            end
            if (junk) begin in_valid = 1'($urandom); in_nib = 4'($urandom); end
            tick();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(N * N));
        clr_acc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == stall_k) begin
                held      = out_nib;
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) tick();
                check_eq("stall_hold", 32'(out_nib), 32'(held));
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_busy", 32'(busy), 32'd1);
                check_eq("stall_done", 32'(done), 32'd0);
            end else if (junk) begin
                while ($urandom_range(0, 2) == 0) begin
                    out_ready = 1'b0;
                    in_valid  = 1'($urandom);
                    tick();
                end
            end
            check_eq("out_valid", 32'(out_valid), 32'd1);
            res[4*k +: 4] = out_nib;
            out_ready = 1'b1;
            if (junk) in_valid = 1'($urandom);
            tick();
            check_eq("done", 32'(done), (k == 3) ? 32'd1 : 32'd0);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic op_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic mode, input bit bubbles, input int stall_k,
                                input int stall_len, input bit clr_in_load, input bit junk);
        int unsigned full;
        logic [15:0] exp;
        full = 32'(a) * 32'(b) + (mode ? 32'(acc_ref) : 32'd0);
        exp  = full[15:0];
        run_op(a, b, mode, bubbles, stall_k, stall_len, clr_in_load, junk, last_res);
        $display("[TB] op %s: A=%02h B=%02h mode=%0d -> %04h (expect %04h)", tag, a, b, mode, last_res, exp);
        check_eq(tag, 32'(last_res), 32'(exp));
        acc_ref = exp;
    endtask

    // One operation on the OP_NIBBLES=1 instance
    task automatic op1_and_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                                 input logic mode);
        int unsigned full;
        logic [7:0]  exp;
        int          lat;
        full = 32'(a) * 32'(b) + (mode ? 32'(acc_ref1) : 32'd0);
        exp  = full[7:0];
        last_res1 = '0;
        in_valid1 = 1'b1; in_nib1 = a; acc_mode1 = mode;
        tick();
        in_nib1 = b; acc_mode1 = ~mode;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 40) begin tick(); lat++; end
        check_eq("n1_latency", 32'(lat), 32'd1);
        for (int k = 0; k < 2; k++) begin
            last_res1[4*k +: 4] = out_nib1;
            out_ready1 = 1'b1;
            tick();
            check_eq("n1_done", 32'(done1), (k == 1) ? 32'd1 : 32'd0);
        end
        out_ready1 = 1'b0;
        $display("[TB] op1 %s: A=%01h B=%01h mode=%0d -> %02h (expect %02h)", tag, a, b, mode, last_res1, exp);
        check_eq(tag, 32'(last_res1), 32'(exp));
        acc_ref1 = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_nib = '0; acc_mode = 1'b0; clr_acc = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_nib1 = '0; acc_mode1 = 1'b0; clr_acc1 = 1'b0; out_ready1 = 1'b0;
        acc_ref = '0; acc_ref1 = '0;
        #3;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_nib", 32'(out_nib), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_in_ready1", 32'(in_ready1), 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Directed cases
        op_and_check("t1_b7x5d", 8'hB7, 8'h5D, 1'b0, 0, 9, 0, 0, 0);
        check_eq("t1_literal", 32'(last_res), 32'h427B);
        op_and_check("t2_mac", 8'h02, 8'h03, 1'b1, 0, 9, 0, 0, 0);
        check_eq("t2_literal", 32'(last_res), 32'h4281);
        op_and_check("t3_ffxff", 8'hFF, 8'hFF, 1'b0, 0, 9, 0, 0, 0);
        check_eq("t3a_literal", 32'(last_res), 32'hFE01);
        op_and_check("t3_wrap", 8'hFF, 8'hFF, 1'b1, 0, 9, 0, 0, 0);
        check_eq("t3b_literal", 32'(last_res), 32'hFC02);
        op_and_check("t4_backpressure", 8'h9C, 8'hE3, 1'b1, 0, 2, 5, 0, 0);

        // Clear in IDLE, then clear held through LOAD/MUL must be ignored
        clr_acc = 1'b1; tick(); clr_acc = 1'b0; acc_ref = '0;
        op_and_check("t5_after_clr", 8'h03, 8'h04, 1'b1, 0, 9, 0, 0, 0);
        check_eq("t5_literal", 32'(last_res), 32'h000C);
        op_and_check("t5_clr_in_mul", 8'h03, 8'h04, 1'b1, 0, 9, 0, 1, 0);

        // Randomized operations with bubbles, backpressure and ignored inputs
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                clr_acc = 1'b1; tick(); clr_acc = 1'b0; acc_ref = '0;
            end
            op_and_check("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1,
                         int'($urandom_range(0, 5)), int'($urandom_range(1, 3)), 1'($urandom), 1);
        end

        // Reset dropped mid-MUL
        in_valid = 1'b1; in_nib = 4'h2; acc_mode = 1'b1; tick();
        in_nib = 4'h1; tick();
        in_nib = 4'h4; tick();
        in_nib = 4'h3; tick();
        in_valid = 1'b0;
        tick();
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_out_valid", 32'(out_valid), 32'd0);
        check_eq("t6_in_ready", 32'(in_ready), 32'd1);
        check_eq("t6_out_nib", 32'(out_nib), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        acc_ref = '0; acc_ref1 = '0;
        tick();
        op_and_check("t6_after_rst", 8'h01, 8'h01, 1'b1, 0, 9, 0, 0, 0);
        check_eq("t6_literal", 32'(last_res), 32'h0001);

        // Single-nibble operand instance
        op1_and_check("n1_bx5", 4'hB, 4'h5, 1'b0);
        check_eq("n1_literal", 32'(last_res1), 32'h37);
        op1_and_check("n1_mac", 4'h2, 4'h3, 1'b1);
        for (int t = 0; t < 6; t++) begin
            op1_and_check("n1_rand", 4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
